nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder
//   Adds two 16-bit unsigned operands plus a carry-in, one 4-bit nibble per
//   clock, through a single shared four_bit_adder. A request takes four RUN
//   cycles. The result is published, together with a one-cycle done pulse,
//   only on the final RUN edge.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request; accepted only while idle
//   a      in  16   operand A
//   b      in  16   operand B
//   cin    in   1   carry into nibble 0
//   busy   out  1   addition in progress
//   done   out  1   one-cycle pulse, sum/cout valid
//   sum    out 16   (a + b + cin) mod 2^16, held until next completion
//   cout   out  1   carry out of bit 15, held with sum
// ----------------------------------------------------------------------------

// Nibble adder: the only arithmetic on the data path.
module four_bit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold last result
// RUN   | adding nibble k_q each cycle, k_q = 0..3
module nibble_serial_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q;
    logic [1:0]  k_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        carry_q;
    logic [15:0] shadow_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] sum_q;
    logic        cout_q;

    logic [3:0]  nib_a_d;
    logic [3:0]  nib_b_d;
    logic [3:0]  nib_s_d;
    logic        nib_c_d;
    logic [3:0]  nib_base_d;

    assign nib_base_d = {k_q, 2'b00};
    assign nib_a_d    = a_q[nib_base_d +: 4];
    assign nib_b_d    = b_q[nib_base_d +: 4];

    four_bit_adder u_add (
        .a_i (nib_a_d),
        .b_i (nib_b_d),
        .c_i (carry_q),
        .s_o (nib_s_d),
        .c_o (nib_c_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            carry_q  <= 1'b0;
            shadow_q <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= 16'h0000;
            cout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        k_q     <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    shadow_q[nib_base_d +: 4] <= nib_s_d;
                    carry_q <= nib_c_d;
                    k_q     <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        // Shadow register still lacks nibble 3 on this edge,
                        // so splice the live adder output in directly. The
                        // final carry goes only to cout.
                        sum_q   <= {nib_s_d, shadow_q[11:0]};
                        cout_q  <= nib_c_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
